// File: rtl/axi_sdram_pkg.sv
// Shared definitions for the AXI-SDRAM bridge: command word layout and arbiter grant encoding.
package axi_sdram_pkg;

  localparam int unsigned AXI_ADDR_W    = 32;
  localparam int unsigned AXI_LEN_W     = 8;

  // Command word {is_wr, word_addr, len}, is_wr in the MSB
  localparam int unsigned CMD_LEN_LSB   = 0;
  localparam int unsigned CMD_LEN_MSB   = AXI_LEN_W - 1;
  localparam int unsigned CMD_ADDR_LSB  = AXI_LEN_W;
  localparam int unsigned CMD_ADDR_MSB  = CMD_ADDR_LSB + AXI_ADDR_W - 3;
  localparam int unsigned CMD_IS_WR_BIT = CMD_ADDR_MSB + 1;
  localparam int unsigned CMD_W         = CMD_IS_WR_BIT + 1;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

  typedef struct packed {
    logic                  is_wr;
    logic [AXI_ADDR_W-3:0] word_addr;
    logic [AXI_LEN_W-1:0]  len;
  } sdram_cmd_t;

endpackage

// File: rtl/axi_sdram_addr_arb_if.sv
// AW/AR request channels, SDRAM command stream and unaligned-address FIFO write port of the arbiter.
interface axi_sdram_addr_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 8
);
  localparam int unsigned CMD_W = 1 + (ADDR_W - 2) + LEN_W;

  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [LEN_W-1:0]  s_axi_awlen;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [LEN_W-1:0]  s_axi_arlen;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [CMD_W-1:0]  m_axis_cmd_data;
  logic              m_axis_cmd_valid;
  logic              m_axis_cmd_ready;
  logic              wt_burst_unaligned_msg_fifo_wen;
  logic [1:0]        wt_burst_unaligned_msg_fifo_din;
  logic              wt_burst_unaligned_msg_fifo_full_n;

  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    output m_axis_cmd_data, m_axis_cmd_valid,
    input  m_axis_cmd_ready,
    output wt_burst_unaligned_msg_fifo_wen, wt_burst_unaligned_msg_fifo_din,
    input  wt_burst_unaligned_msg_fifo_full_n
  );

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    input  m_axis_cmd_data, m_axis_cmd_valid,
    output m_axis_cmd_ready,
    input  wt_burst_unaligned_msg_fifo_wen, wt_burst_unaligned_msg_fifo_din,
    output wt_burst_unaligned_msg_fifo_full_n
  );

endinterface

// File: rtl/axi_sdram_cmd_slot.sv
// Single-entry valid/ready register: loads a new command, holds it while stalled, drains on ready.
module axi_sdram_cmd_slot #(
  parameter int unsigned W = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         slot_free
);

  // Free when empty or when the held command leaves this cycle, so load and drain can overlap
  assign slot_free = ~valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_sdram_addr_arb.sv
// Round-robin arbiter sharing the SDRAM command port between AXI AW and AR, with a one-deep command slot.
module axi_sdram_addr_arb
  import axi_sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned LEN_W  = AXI_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  axi_sdram_addr_arb_if.slave bus
);

  localparam int unsigned CMD_LW = 1 + (ADDR_W - 2) + LEN_W;

  grant_e              last_grant_q;
  grant_e              last_grant_d;
  logic                slot_free;
  logic                wr_elig;
  logic                rd_elig;
  logic                grant_wr;
  logic                grant_rd;
  logic [CMD_LW-1:0]   load_data;
  logic                unused_araddr_lsb;

  // Round-robin state: side granted most recently
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= GRANT_RD;
    else     last_grant_q <= last_grant_d;
  end

  // Grant selection and command assembly; writes need room in the unaligned-address FIFO
  always_comb begin
    wr_elig      = bus.s_axi_awvalid & bus.wt_burst_unaligned_msg_fifo_full_n;
    rd_elig      = bus.s_axi_arvalid;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    last_grant_d = last_grant_q;
    load_data    = '0;
    if (!rst && slot_free) begin
      if (wr_elig && (!rd_elig || last_grant_q == GRANT_RD)) grant_wr = 1'b1;
      else if (rd_elig)                                       grant_rd = 1'b1;
    end
    if (grant_wr) begin
      last_grant_d = GRANT_WR;
      load_data    = {1'b1, bus.s_axi_awaddr[ADDR_W-1:2], bus.s_axi_awlen};
    end else if (grant_rd) begin
      last_grant_d = GRANT_RD;
      load_data    = {1'b0, bus.s_axi_araddr[ADDR_W-1:2], bus.s_axi_arlen};
    end
  end

  assign bus.s_axi_awready                   = grant_wr;
  assign bus.s_axi_arready                   = grant_rd;
  assign bus.wt_burst_unaligned_msg_fifo_wen = grant_wr;
  assign bus.wt_burst_unaligned_msg_fifo_din = bus.s_axi_awaddr[1:0];

  // Read bursts are word-aligned downstream; the byte offset is irrelevant for AR
  assign unused_araddr_lsb = ^bus.s_axi_araddr[1:0];

  axi_sdram_cmd_slot #(
    .W (CMD_LW)
  ) u_cmd_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (grant_wr | grant_rd),
    .load_data (load_data),
    .ready     (bus.m_axis_cmd_ready),
    .valid     (bus.m_axis_cmd_valid),
    .data      (bus.m_axis_cmd_data),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_axi_sdram_addr_arb.sv
// Self-checking bench for axi_sdram_addr_arb: directed scenarios plus randomized traffic against a reference model.
module tb_axi_sdram_addr_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sdram_addr_arb_if #(.ADDR_W(32), .LEN_W(8)) bus ();

  axi_sdram_addr_arb #(.ADDR_W(32), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: expected slot contents and whose turn it is on a tie
  bit          m_valid   = 1'b0;
  bit          m_last_wr = 1'b0;
  logic [38:0] m_cmd     = '0;
  bit          e_gw, e_gr;
  bit          l_gw, l_gr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Mid-cycle: predict grants from the arbitration rules and compare every output
  task automatic sample();
    bit free, we, re;
    @(negedge clk);
    free = !m_valid || bus.m_axis_cmd_ready;
    we   = bus.s_axi_awvalid && bus.wt_burst_unaligned_msg_fifo_full_n;
    re   = bus.s_axi_arvalid;
    e_gw = 1'b0;
    e_gr = 1'b0;
    if (!rst && free) begin
      if (we && re) begin
        if (m_last_wr) e_gr = 1'b1;
        else           e_gw = 1'b1;
      end else if (we) e_gw = 1'b1;
      else if (re)     e_gr = 1'b1;
    end
    check_eq("awready",   64'(bus.s_axi_awready), 64'(e_gw));
    check_eq("arready",   64'(bus.s_axi_arready), 64'(e_gr));
    check_eq("fifo_wen",  64'(bus.wt_burst_unaligned_msg_fifo_wen), 64'(e_gw));
    if (e_gw) check_eq("fifo_din", 64'(bus.wt_burst_unaligned_msg_fifo_din), 64'(bus.s_axi_awaddr[1:0]));
    check_eq("cmd_valid", 64'(bus.m_axis_cmd_valid), 64'(m_valid));
    check_eq("cmd_data",  64'(bus.m_axis_cmd_data), 64'(m_cmd));
  endtask

  task automatic tick();
    @(posedge clk);
    l_gw = e_gw;
    l_gr = e_gr;
    if (rst) begin
      m_valid   = 1'b0;
      m_cmd     = '0;
      m_last_wr = 1'b0;
    end else if (e_gw) begin
      m_valid   = 1'b1;
      m_cmd     = {1'b1, bus.s_axi_awaddr[31:2], bus.s_axi_awlen};
      m_last_wr = 1'b1;
    end else if (e_gr) begin
      m_valid   = 1'b1;
      m_cmd     = {1'b0, bus.s_axi_araddr[31:2], bus.s_axi_arlen};
      m_last_wr = 1'b0;
    end else if (bus.m_axis_cmd_ready) begin
      m_valid   = 1'b0;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic drive_idle();
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_awaddr  = '0;
    bus.s_axi_awlen   = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arlen   = '0;
    bus.m_axis_cmd_ready = 1'b1;
    bus.wt_burst_unaligned_msg_fifo_full_n = 1'b1;
  endtask

  initial begin
    bit prev_w;
    logic [38:0] exp_cmd;

    drive_idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Single AW: FIFO write with the byte offset, command one cycle later
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_awaddr  = 32'h0000_1006;
    bus.s_axi_awlen   = 8'd3;
    sample();
    check_eq("aw_first_ready", 64'(bus.s_axi_awready), 64'd1);
    check_eq("aw_first_din",   64'(bus.wt_burst_unaligned_msg_fifo_din), 64'd2);
    tick();
    bus.s_axi_awvalid = 1'b0;
    sample();
    exp_cmd = {1'b1, 30'h0000_0401, 8'd3};
    check_eq("aw_first_cmd",   64'(bus.m_axis_cmd_data), 64'(exp_cmd));
    check_eq("aw_first_valid", 64'(bus.m_axis_cmd_valid), 64'd1);
    tick();

    // Both channels held valid: grants must alternate (last grant was a write)
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_awaddr  = 32'h0000_2001;
    bus.s_axi_awlen   = 8'd7;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr  = 32'h0000_3000;
    bus.s_axi_arlen   = 8'd15;
    prev_w = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      check_eq("alt_wr",  64'(bus.s_axi_awready), 64'(!prev_w));
      check_eq("alt_one", 64'(bus.s_axi_awready ^ bus.s_axi_arready), 64'd1);
      prev_w = bus.s_axi_awready;
      tick();
    end

    // FIFO full: reads keep flowing, writes wait
    bus.wt_burst_unaligned_msg_fifo_full_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("full_aw_blocked", 64'(bus.s_axi_awready), 64'd0);
      check_eq("full_ar_served",  64'(bus.s_axi_arready), 64'd1);
      tick();
    end
    bus.wt_burst_unaligned_msg_fifo_full_n = 1'b1;
    sample();
    check_eq("unfull_w_next", 64'(bus.s_axi_awready), 64'd1);
    tick();

    // Downstream stall: slot holds, no grants; release drains and reloads without a bubble
    bus.s_axi_awvalid = 1'b0;
    cyc();
    bus.m_axis_cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check_eq("stall_no_ar", 64'(bus.s_axi_arready), 64'd0);
      check_eq("stall_valid", 64'(bus.m_axis_cmd_valid), 64'd1);
      tick();
    end
    bus.m_axis_cmd_ready = 1'b1;
    sample();
    check_eq("release_ar", 64'(bus.s_axi_arready), 64'd1);
    tick();
    bus.s_axi_arvalid = 1'b0;
    sample();
    check_eq("release_valid", 64'(bus.m_axis_cmd_valid), 64'd1);
    tick();

    // Top-of-range read address and maximum length
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr  = 32'hFFFF_FFFC;
    bus.s_axi_arlen   = 8'hFF;
    cyc();
    bus.s_axi_arvalid = 1'b0;
    sample();
    exp_cmd = {1'b0, 30'h3FFF_FFFF, 8'hFF};
    check_eq("max_cmd", 64'(bus.m_axis_cmd_data), 64'(exp_cmd));
    tick();

    // Reset while a command is pending and AW is requesting
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr  = 32'h0000_4000;
    cyc();
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_awaddr  = 32'h0000_5003;
    rst = 1'b1;
    sample();
    check_eq("rst_no_wen", 64'(bus.wt_burst_unaligned_msg_fifo_wen), 64'd0);
    tick();
    rst = 1'b0;
    sample();
    check_eq("rst_valid_drop", 64'(bus.m_axis_cmd_valid), 64'd0);
    check_eq("rst_first_w",    64'(bus.s_axi_awready), 64'd1);
    tick();

    // Randomized traffic; requests stay asserted until accepted
    drive_idle();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_arvalid = 1'b0;
      end else begin
        if (!bus.s_axi_awvalid || l_gw) begin
          bus.s_axi_awvalid = ($urandom_range(0, 2) != 0);
          bus.s_axi_awaddr  = $urandom;
          bus.s_axi_awlen   = 8'($urandom_range(0, 255));
        end
        if (!bus.s_axi_arvalid || l_gr) begin
          bus.s_axi_arvalid = ($urandom_range(0, 2) != 0);
          bus.s_axi_araddr  = $urandom;
          bus.s_axi_arlen   = 8'($urandom_range(0, 255));
        end
      end
      bus.m_axis_cmd_ready = ($urandom_range(0, 3) != 0);
      bus.wt_burst_unaligned_msg_fifo_full_n = ($urandom_range(0, 4) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
